imem_fetch_responder: RTL and testbench

//  Responder end of the core's instruction-fetch interface: accepts fetch requests (word address),

---
 rtl/imem_fetch_responder_if.sv | 32 +++
 rtl/imem_fetch_responder.sv | 126 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_if.sv
// Instruction-fetch / program-load bus between the core IF stage (master)
// and the instruction memory responder (slave).
interface imem_fetch_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  // program-load write port
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  // fetch request channel
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  // fetch response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output ld_valid, ld_addr, ld_data,
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction memory responder: accepts word-address fetches, performs a
// registered read, and returns results in order through a 2-entry queue.
// Also hosts the program-load write port, which wins over fetches.
module imem_fetch_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_fetch_responder_if.slave    bus,
  output logic                     busy,
  output logic [CNT_W-1:0]         fetch_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  // storage array and read stage
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;
  logic              pending_reg;
  logic              err_reg;

  // response queue
  logic [DATA_W-1:0] q_data_reg [2];
  logic              q_err_reg  [2];
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [CNT_W-1:0]  fetch_cnt_reg;

  logic              ld_in_range;
  logic              req_in_range;
  logic [IDX_W-1:0]  ld_idx;
  logic [IDX_W-1:0]  req_idx;
  logic              fire;
  logic              push;
  logic              pop;
  logic [2:0]        credit;
  logic [DATA_W-1:0] push_data;

  assign ld_in_range  = {1'b0, bus.ld_addr}  < DEPTH_L;
  assign req_in_range = {1'b0, bus.req_addr} < DEPTH_L;
  assign ld_idx       = bus.ld_addr[IDX_W-1:0];
  assign req_idx      = bus.req_addr[IDX_W-1:0];

  // Handshake and credit: slots already used or promised to the read in
  // flight, minus the one being freed this cycle, must leave room.
  always_comb begin
    pop           = (count_reg != 2'd0) && bus.rsp_ready;
    push          = pending_reg;
    credit        = {1'b0, count_reg} + {2'b00, pending_reg} - {2'b00, pop};
    bus.req_ready = !bus.ld_valid && (credit < 3'd2);
    fire          = bus.req_valid && bus.req_ready;
    push_data     = err_reg ? '0 : rd_data_reg;
    count_next    = count_reg + {1'b0, push} - {1'b0, pop};
  end

  // Memory write and registered read; the array is never reset so a loaded
  // program survives rst_n. Out-of-range reads leave rd_data untouched.
  always_ff @(posedge clk) begin
    if (bus.ld_valid && ld_in_range) begin
      mem[ld_idx] <= bus.ld_data;
    end
    if (fire && req_in_range) begin
      rd_data_reg <= mem[req_idx];
    end
  end

  // Read-in-flight flag and its error tag; reset drops the in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= fire;
      if (fire) begin
        err_reg <= !req_in_range;
      end
    end
  end

  // Queue storage: the read result lands in the slot under the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_data_reg[i] <= '0;
        q_err_reg[i]  <= 1'b0;
      end
    end else if (push) begin
      q_data_reg[wr_ptr_reg] <= push_data;
      q_err_reg[wr_ptr_reg]  <= err_reg;
    end
  end

  // Queue pointers, occupancy and accepted-fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= 2'd0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      fetch_cnt_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= !wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      if (fire) begin
        fetch_cnt_reg <= fetch_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.rsp_valid = (count_reg != 2'd0);
  assign bus.rsp_data  = q_data_reg[rd_ptr_reg];
  assign bus.rsp_err   = q_err_reg[rd_ptr_reg];
  assign busy          = pending_reg || (count_reg != 2'd0);
  assign fetch_cnt     = fetch_cnt_reg;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (DEPTH=200, CNT_W=4 instance).
module tb_imem_fetch_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [3:0] fetch_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] img [4];
  logic [3:0]  exp_cnt;

  imem_fetch_responder_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  imem_fetch_responder #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(200), .CNT_W(4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("[%0t] %s obs=%0h exp=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    img[0] = 16'hA0CA; img[1] = 16'h02A0; img[2] = 16'h1234; img[3] = 16'hFFFF;
    rst_n = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    rst_n = 1'b1;
    tick();

    // program load; req_ready must drop while loading
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_addr = 8'(i); bus.ld_data = img[i];
      bus.req_valid = 1'b1; bus.req_addr = 8'd0;
      #1;
      chk("ld_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.ld_valid = 1'b0; bus.req_valid = 1'b0;
    chk("ld_no_accept_cnt", fetch_cnt, 0);

    // 1: streaming fetches with rsp_ready held high
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = (k < 4); bus.req_addr = 8'(k % 4);
      #1;
      if (k < 4) chk("t1_req_ready", bus.req_ready, 1);
      chk("t1_rsp_valid", bus.rsp_valid, (k >= 2) ? 1 : 0);
      if (k >= 2) chk("t1_rsp_data", bus.rsp_data, img[k-2]);
      tick();
    end
    chk("t1_empty", bus.rsp_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_cnt", fetch_cnt, 4);

    // 2: back-pressure
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 8'd0; #1;
    chk("t2_rdy0", bus.req_ready, 1);
    tick();
    bus.req_addr = 8'd1; #1;
    chk("t2_rdy1", bus.req_ready, 1);
    tick();
    bus.req_addr = 8'd2; #1;
    chk("t2_rdy2_blocked", bus.req_ready, 0);
    chk("t2_head_a", bus.rsp_data, 16'hA0CA);
    tick();
    chk("t2_rdy2_still_blocked", bus.req_ready, 0);
    chk("t2_head_hold", bus.rsp_data, 16'hA0CA);
    chk("t2_busy", busy, 1);
    bus.rsp_ready = 1'b1; #1;
    chk("t2_rdy_on_pop", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0; #1;
    chk("t2_second", bus.rsp_data, 16'h02A0);
    tick();
    chk("t2_third_valid", bus.rsp_valid, 1);
    chk("t2_third", bus.rsp_data, 16'h1234);
    tick();
    chk("t2_empty", bus.rsp_valid, 0);
    chk("t2_cnt", fetch_cnt, 7);

    // 3: load and fetch in the same cycle, load wins
    bus.ld_valid = 1'b1; bus.ld_addr = 8'd2; bus.ld_data = 16'hBEEF;
    bus.req_valid = 1'b1; bus.req_addr = 8'd2; #1;
    chk("t3_ld_blocks", bus.req_ready, 0);
    tick();
    bus.ld_valid = 1'b0; #1;
    chk("t3_rdy", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("t3_valid", bus.rsp_valid, 1);
    chk("t3_new_data", bus.rsp_data, 16'hBEEF);
    img[2] = 16'hBEEF;
    tick();
    chk("t3_cnt", fetch_cnt, 8);

    // 4: out-of-range fetches
    bus.req_valid = 1'b1; bus.req_addr = 8'd250; tick();
    bus.req_addr = 8'd200; tick();
    bus.req_addr = 8'd1; #1;
    chk("t4_250_data", bus.rsp_data, 0);
    chk("t4_250_err", bus.rsp_err, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("t4_200_data", bus.rsp_data, 0);
    chk("t4_200_err", bus.rsp_err, 1);
    tick();
    chk("t4_1_data", bus.rsp_data, 16'h02A0);
    chk("t4_1_err", bus.rsp_err, 0);
    tick();
    chk("t4_cnt", fetch_cnt, 11);

    // 5: reset with one queued and one read in flight
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 8'd0; tick();
    bus.req_addr = 8'd1; tick();
    bus.req_valid = 1'b0;
    chk("t5_pre_valid", bus.rsp_valid, 1);
    rst_n = 1'b0; #1;
    chk("t5_rst_valid", bus.rsp_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cnt", fetch_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_stale", bus.rsp_valid, 0);
    end
    bus.req_valid = 1'b1; bus.req_addr = 8'd0; tick();
    bus.req_valid = 1'b0; tick();
    chk("t5_mem_kept", bus.rsp_data, 16'hA0CA);
    chk("t5_cnt", fetch_cnt, 1);
    tick();

    // 6: 17 back-to-back fetches, 4-bit counter wraps
    exp_cnt = 4'd1;
    for (int k = 0; k < 19; k++) begin
      bus.req_valid = (k < 17); bus.req_addr = 8'(k % 4);
      #1;
      if (k >= 2) chk("t6_data", bus.rsp_data, img[(k-2)%4]);
      tick();
      if (k < 17) exp_cnt = exp_cnt + 4'd1;
      chk("t6_cnt", fetch_cnt, exp_cnt);
    end
    chk("t6_final_cnt", fetch_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
